// File: rtl/uart_ctrl_pkg.sv
// Types and byte-order selection shared by the UART TX and RX control blocks.
// Define TX_CONTROL_MSB_FIRST_EN to transmit the high byte first.
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_BYTE_0,
        ST_WAIT_BYTE_0,
        ST_INTER_DELAY,
        ST_SEND_BYTE_1,
        ST_WAIT_BYTE_1,
        ST_TX_DONE
    } tx_state_t;

`ifdef TX_CONTROL_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif

    // second=0 selects byte 0, second=1 selects byte 1 of the held word
    function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic second);
        pick_byte = (second ^ MSB_FIRST) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/tx_delay_counter.sv
// Counts the idle gap between byte 0 and byte 1; expire marks the last gap cycle.
module tx_delay_counter #(
    parameter int DELAY = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam int             W    = (DELAY < 1) ? 1 : $clog2(DELAY + 1);
    localparam logic [W-1:0]   LAST = W'(DELAY);

    logic [W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (count && cnt_q != LAST) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Saturates at LAST, so a stalled FSM can never see the count wrap back to zero.
    assign expire = count && (({1'b0, cnt_q} + 1'b1) >= {1'b0, LAST});

endmodule

// File: rtl/tx_control.sv
// UART transmit sequencer: sends one or two bytes of a held word to a byte-wide driver.
// Define TX_CONTROL_MSB_FIRST_EN to send the high byte first.
module tx_control
    import uart_ctrl_pkg::*;
#(
    parameter int INTER_DELAY = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tx_start,
    input  logic [15:0] tx_data,
    input  logic        send16,
    input  logic        tx_busy,
    output logic [7:0]  tx_out_data,
    output logic        tx_out_start,
    output logic        busy,
    output logic        done
);

    tx_state_t   state_q, state_d;
    logic [15:0] held_data_q;
    logic        held_send16_q;
    logic        wait_first_q;
    logic [7:0]  out_byte_q;
    logic [7:0]  send_byte;
    logic        dly_load, dly_count, dly_expire;

    assign send_byte = pick_byte(held_data_q, state_q == ST_SEND_BYTE_1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            held_data_q   <= '0;
            held_send16_q <= 1'b0;
            wait_first_q  <= 1'b0;
            out_byte_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && tx_start) begin
                held_data_q   <= tx_data;
                held_send16_q <= send16;
            end
            // The driver raises tx_busy one cycle late, so the first WAIT cycle is blind.
            wait_first_q <= tx_out_start;
            if (tx_out_start) begin
                out_byte_q <= send_byte;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        tx_out_start = 1'b0;
        dly_load     = 1'b0;
        dly_count    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_start) state_d = ST_SEND_BYTE_0;
            end
            ST_SEND_BYTE_0: begin
                if (!tx_busy) begin
                    tx_out_start = 1'b1;
                    state_d      = ST_WAIT_BYTE_0;
                end
            end
            ST_WAIT_BYTE_0: begin
                if (!wait_first_q && !tx_busy) begin
                    if (!held_send16_q) begin
                        state_d = ST_TX_DONE;
                    end else if (INTER_DELAY == 0) begin
                        state_d = ST_SEND_BYTE_1;
                    end else begin
                        state_d  = ST_INTER_DELAY;
                        dly_load = 1'b1;
                    end
                end
            end
            ST_INTER_DELAY: begin
                dly_count = 1'b1;
                if (dly_expire) state_d = ST_SEND_BYTE_1;
            end
            ST_SEND_BYTE_1: begin
                if (!tx_busy) begin
                    tx_out_start = 1'b1;
                    state_d      = ST_WAIT_BYTE_1;
                end
            end
            ST_WAIT_BYTE_1: begin
                if (!wait_first_q && !tx_busy) state_d = ST_TX_DONE;
            end
            ST_TX_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    tx_delay_counter #(
        .DELAY(INTER_DELAY)
    ) u_delay (
        .clock (clock),
        .reset (reset),
        .load  (dly_load),
        .count (dly_count),
        .expire(dly_expire)
    );

    // The strobed byte is presented during its strobe cycle and held in out_byte_q afterwards.
    assign tx_out_data = tx_out_start ? send_byte : out_byte_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_TX_DONE);

endmodule

// File: tb/tb_tx_control.sv
// Self-checking bench for tx_control: directed scenarios then random transfers against a timeline model.
module tb_tx_control;

    localparam int DLY = 16;

    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic        tx_start = 1'b0;
    logic [15:0] tx_data  = 16'h0000;
    logic        send16   = 1'b0;
    logic        tx_busy  = 1'b0;
    logic [7:0]  tx_out_data;
    logic        tx_out_start;
    logic        busy;
    logic        done;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  last_byte = 8'h00;

    tx_control #(
        .INTER_DELAY(DLY)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .send16      (send16),
        .tx_busy     (tx_busy),
        .tx_out_data (tx_out_data),
        .tx_out_start(tx_out_start),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Which byte of the word goes out first depends on the build option.
    function automatic logic [7:0] model_byte(input logic [15:0] w, input bit second);
        bit msb;
`ifdef TX_CONTROL_MSB_FIRST_EN
        msb = 1'b1;
`else
        msb = 1'b0;
`endif
        if (second == msb) return 8'(w % 256);
        return 8'(w / 256);
    endfunction

    // Entered and left at posedge+1. Cycle 0 carries tx_start; the transfer timeline
    // (strobe cycles, gap, done cycle) is worked out up front from the protocol rules.
    task automatic run_txn(input logic [15:0] data, input bit s16, input int lat,
                           input int pre, input int mode);
        int t0, k0, t1, k1, done_c;
        logic [7:0] b0, b1;
        bit es;
        b0     = model_byte(data, 1'b0);
        b1     = model_byte(data, 1'b1);
        t0     = (pre > 1) ? pre : 1;
        k0     = t0 + lat + 1;
        t1     = k0 + 1 + DLY;
        k1     = t1 + lat + 1;
        done_c = s16 ? k1 + 1 : k0 + 1;
        for (int c = 0; c <= done_c; c++) begin
            tx_busy = (c < pre) || (c > t0 && c <= t0 + lat) || (s16 && c > t1 && c <= t1 + lat);
            if (c == 0) begin
                tx_start = 1'b1; tx_data = data; send16 = s16;
            end else if (c == done_c) begin
                tx_start = 1'b1; tx_data = 16'($urandom); send16 = 1'($urandom);
            end else if (mode == 1) begin
                tx_start = 1'($urandom); tx_data = 16'($urandom); send16 = 1'($urandom);
            end else if (mode == 2) begin
                tx_start = 1'b1; tx_data = 16'hFFFF; send16 = !s16;
            end else begin
                tx_start = 1'b0;
            end
            es = (c == t0) || (s16 && c == t1);
            if (c == t0) last_byte = b0;
            else if (s16 && c == t1) last_byte = b1;
            @(negedge clock);
            check($sformatf("strobe d=%h c=%0d", data, c), 16'(tx_out_start), 16'(es));
            check($sformatf("out_data d=%h c=%0d", data, c), 16'(tx_out_data), 16'(last_byte));
            check($sformatf("busy d=%h c=%0d", data, c), 16'(busy), 16'(c != 0));
            check($sformatf("done d=%h c=%0d", data, c), 16'(done), 16'(c == done_c));
            @(posedge clock);
            #1;
        end
        tx_start = 1'b0;
    endtask

    // Two-byte transfer aborted by reset part-way through the gap; leaves reset asserted.
    task automatic run_abort(input logic [15:0] data, input int lat);
        int k0, stop;
        k0   = 1 + lat + 1;
        stop = k0 + 1 + DLY / 2;
        for (int c = 0; c < stop; c++) begin
            tx_busy  = (c > 1 && c <= 1 + lat);
            tx_start = (c == 0);
            tx_data  = data;
            send16   = 1'b1;
            if (c == 1) last_byte = model_byte(data, 1'b0);
            @(negedge clock);
            check($sformatf("abort strobe c=%0d", c), 16'(tx_out_start), 16'(c == 1));
            check($sformatf("abort busy c=%0d", c), 16'(busy), 16'(c != 0));
            @(posedge clock);
            #1;
        end
        tx_busy = 1'b0;
        #2 reset = 1'b0;
        #1;
        last_byte = 8'h00;
        check("async strobe", 16'(tx_out_start), 16'h0);
        check("async busy", 16'(busy), 16'h0);
        check("async done", 16'(done), 16'h0);
        check("async out_data", 16'(tx_out_data), 16'h0);
        for (int i = 0; i < 3; i++) begin
            tx_start = 1'b1;
            @(negedge clock);
            check($sformatf("in_reset strobe %0d", i), 16'(tx_out_start), 16'h0);
            check($sformatf("in_reset busy %0d", i), 16'(busy), 16'h0);
            @(posedge clock);
            #1;
        end
        tx_start = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst strobe", 16'(tx_out_start), 16'h0);
        check("rst busy", 16'(busy), 16'h0);
        check("rst done", 16'(done), 16'h0);
        check("rst out_data", 16'(tx_out_data), 16'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        run_txn(16'hA55A, 1'b0, 10, 0, 0);
        run_txn(16'h1234, 1'b1, 4, 0, 0);
        run_txn(16'h1234, 1'b1, 3, 5, 0);
        run_txn(16'h1234, 1'b1, 6, 0, 2);

        run_abort(16'hBEEF, 5);
        reset = 1'b1;
        run_txn(16'h1234, 1'b0, 2, 0, 0);

        for (int n = 0; n < 20; n++) begin
            run_txn(16'($urandom), 1'($urandom), int'($urandom_range(1, 12)),
                    int'($urandom_range(0, 6)), int'($urandom_range(0, 2)));
        end

        tx_busy = 1'b0;
        @(negedge clock);
        check("settle busy", 16'(busy), 16'h0);
        check("settle out_data", 16'(tx_out_data), 16'(last_byte));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
